// File: rtl/tile_pwr_seq.sv
// Per-tile clock-enable / reset sequencer. Each tile runs its own small FSM so
// tiles power up and down independently while sharing one command port.
module tile_pwr_seq #(
  parameter int NumTiles      = 16,
  parameter int RstHoldCycles = 8,
  parameter int ClkHoldCycles = 4,
  localparam int MaxHold = (RstHoldCycles > ClkHoldCycles) ? RstHoldCycles : ClkHoldCycles,
  localparam int CntW    = $clog2(MaxHold + 1),
  localparam int IdxW    = (NumTiles > 1) ? $clog2(NumTiles) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [IdxW-1:0]     cmd_tile_i,
  input  logic                cmd_on_i,
  output logic [NumTiles-1:0] tile_clk_en_o,
  output logic [NumTiles-1:0] tile_rst_no,
  output logic [NumTiles-1:0] tile_on_o,
  output logic [NumTiles-1:0] busy_o,
  output logic [NumTiles-1:0] done_o,
  output logic                err_o
);

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_PWRUP = 2'd1,
    S_ON    = 2'd2,
    S_PWRDN = 2'd3
  } state_t;

  localparam logic [IdxW:0]   NumTilesW = (IdxW + 1)'(NumTiles);
  localparam logic [CntW-1:0] RstLoad   = CntW'(RstHoldCycles - 1);
  localparam logic [CntW-1:0] ClkLoad   = CntW'(ClkHoldCycles - 1);
  localparam logic [CntW-1:0] CntOne    = CntW'(1);

  logic [NumTiles-1:0] w_idle;
  logic                w_in_range;
  logic                w_tgt_idle;
  logic                w_accept;
  logic                r_err;

  assign w_in_range = ({1'b0, cmd_tile_i} < NumTilesW);

  // Explicit compare loop keeps out-of-range indices from selecting past the vector.
  always_comb begin
    w_tgt_idle = 1'b0;
    for (int i = 0; i < NumTiles; i++) begin
      if (cmd_tile_i == IdxW'(i)) begin
        w_tgt_idle = w_idle[i];
      end
    end
  end

  assign cmd_ready_o = !w_in_range || w_tgt_idle;
  assign w_accept    = cmd_valid_i && cmd_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_accept && !w_in_range;
    end
  end

  assign err_o = r_err;

  for (genvar gi = 0; gi < NumTiles; gi++) begin : g_tile
    state_t          r_state;
    logic [CntW-1:0] r_cnt;
    logic            r_clk_en;
    logic            r_rst_n;
    logic            r_on;
    logic            r_busy;
    logic            r_done;
    logic            w_hit;

    assign w_hit = w_accept && w_in_range && (cmd_tile_i == IdxW'(gi));

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_state  <= S_OFF;
        r_cnt    <= '0;
        r_clk_en <= 1'b0;
        r_rst_n  <= 1'b0;
        r_on     <= 1'b0;
        r_busy   <= 1'b0;
        r_done   <= 1'b0;
      end else begin
        r_done <= 1'b0;
        case (r_state)
          S_OFF: begin
            if (w_hit && cmd_on_i) begin
              r_state  <= S_PWRUP;
              r_cnt    <= RstLoad;
              r_clk_en <= 1'b1;
              r_busy   <= 1'b1;
            end else if (w_hit) begin
              r_done <= 1'b1;
            end
          end
          S_PWRUP: begin
            if (r_cnt == '0) begin
              r_state <= S_ON;
              r_rst_n <= 1'b1;
              r_on    <= 1'b1;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_cnt <= r_cnt - CntOne;
            end
          end
          S_ON: begin
            // Reset goes low first; the clock keeps running through the hold.
            if (w_hit && !cmd_on_i) begin
              r_state <= S_PWRDN;
              r_cnt   <= ClkLoad;
              r_rst_n <= 1'b0;
              r_on    <= 1'b0;
              r_busy  <= 1'b1;
            end else if (w_hit) begin
              r_done <= 1'b1;
            end
          end
          S_PWRDN: begin
            if (r_cnt == '0) begin
              r_state  <= S_OFF;
              r_clk_en <= 1'b0;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
            end else begin
              r_cnt <= r_cnt - CntOne;
            end
          end
          default: begin
            r_state  <= S_OFF;
            r_cnt    <= '0;
            r_clk_en <= 1'b0;
            r_rst_n  <= 1'b0;
            r_on     <= 1'b0;
            r_busy   <= 1'b0;
          end
        endcase
      end
    end

    assign tile_clk_en_o[gi] = r_clk_en;
    assign tile_rst_no[gi]   = r_rst_n;
    assign tile_on_o[gi]     = r_on;
    assign busy_o[gi]        = r_busy;
    assign done_o[gi]        = r_done;
    assign w_idle[gi]        = ~r_busy;
  end

endmodule

// File: tb/tb_tile_pwr_seq.sv
// Directed scenarios plus a randomized run against a time-based reference model.
// A second 20-tile instance makes an out-of-range index (20) expressible.
module tb_tile_pwr_seq;

  localparam int NT = 16;
  localparam int RH = 8;
  localparam int CH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [3:0]    cmd_tile = 4'd0;
  logic          cmd_on = 1'b0;
  logic [NT-1:0] clk_en, rst_n, t_on, busy, done;
  logic          err;

  logic          v2 = 1'b0;
  logic          r2;
  logic [4:0]    t2 = 5'd0;
  logic          on2 = 1'b0;
  logic [19:0]   ce2, rn2, on2o, b2, d2;
  logic          e2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tile_pwr_seq u_dut (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_tile_i(cmd_tile), .cmd_on_i(cmd_on), .tile_clk_en_o(clk_en),
    .tile_rst_no(rst_n), .tile_on_o(t_on), .busy_o(busy), .done_o(done), .err_o(err)
  );

  tile_pwr_seq #(.NumTiles(20)) u_dut20 (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(v2), .cmd_ready_o(r2),
    .cmd_tile_i(t2), .cmd_on_i(on2), .tile_clk_en_o(ce2),
    .tile_rst_no(rn2), .tile_on_o(on2o), .busy_o(b2), .done_o(d2), .err_o(e2)
  );

  // Reference model: a tile is "busy" until the edge its transition ends, then
  // its outputs simply reflect the last requested power level.
  int            cyc = 0;
  int            m_end [NT];
  int            m_done [NT];
  logic [NT-1:0] m_tgt = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_tgt <= '0;
      for (int t = 0; t < NT; t++) begin
        m_end[t]  <= cyc + 1;
        m_done[t] <= -1;
      end
    end else if (cmd_valid && cyc >= m_end[cmd_tile]) begin
      if (m_tgt[cmd_tile] == cmd_on) begin
        m_done[cmd_tile] <= cyc + 1;
      end else begin
        m_tgt[cmd_tile]  <= cmd_on;
        m_end[cmd_tile]  <= cyc + 1 + (cmd_on ? RH : CH);
        m_done[cmd_tile] <= cyc + 1 + (cmd_on ? RH : CH);
      end
    end
  end

  function automatic logic [NT-1:0] exp_busy();
    logic [NT-1:0] v;
    v = '0;
    for (int t = 0; t < NT; t++) v[t] = (cyc < m_end[t]);
    return v;
  endfunction

  function automatic logic [NT-1:0] exp_done();
    logic [NT-1:0] v;
    v = '0;
    for (int t = 0; t < NT; t++) v[t] = (m_done[t] == cyc);
    return v;
  endfunction

  // Drives a command from a falling edge, waits (bounded) for ready, returns
  // at the falling edge after the accepting edge with valid dropped.
  task automatic issue(input int tile, input logic on, input int bound);
    int w;
    w = 0;
    cmd_valid = 1'b1;
    cmd_tile  = 4'(tile);
    cmd_on    = on;
    #1;
    while (!cmd_ready && w < bound) begin
      @(negedge clk);
      #1;
      w++;
    end
    n_vec++;
    if (cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL issue_timeout tile %0d: ready got %b required 1 within %0d cycles", tile, cmd_ready, bound);
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    $display("cmd tile=%0d on=%0d accepted after %0d stall cycles", tile, on, w);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      n_vec++;
      if ({clk_en, rst_n, t_on, busy, done} !== '0) begin
        n_err++;
        $display("FAIL reset_outputs c%0d: clk_en=%h rst_n=%h on=%h busy=%h done=%h required all 0", i, clk_en, rst_n, t_on, busy, done);
      end
      n_vec++;
      if (cmd_ready !== 1'b1 || err !== 1'b0) begin
        n_err++;
        $display("FAIL reset_ready_err c%0d: ready=%b err=%b required 1/0", i, cmd_ready, err);
      end
      n_vec++;
      if ({ce2, rn2, e2, r2} !== {41'd0, 1'b1}) begin
        n_err++;
        $display("FAIL reset_inst20 c%0d: clk_en=%h rst_n=%h err=%b ready=%b required 0/0/0/1", i, ce2, rn2, e2, r2);
      end
    end
  endtask

  task automatic test_power_on();
    issue(3, 1'b1, 4);
    for (int d = 0; d <= RH + 1; d++) begin
      if (d > 0) @(negedge clk);
      n_vec++;
      if (clk_en !== 16'h0008) begin
        n_err++;
        $display("FAIL pwr_on_clk_en d%0d: got %h required 0008", d, clk_en);
      end
      n_vec++;
      if (rst_n !== ((d >= RH) ? 16'h0008 : 16'h0000)) begin
        n_err++;
        $display("FAIL pwr_on_rst_n d%0d: got %h required %h", d, rst_n, (d >= RH) ? 16'h0008 : 16'h0000);
      end
      n_vec++;
      if (done !== ((d == RH) ? 16'h0008 : 16'h0000) || busy !== ((d < RH) ? 16'h0008 : 16'h0000)) begin
        n_err++;
        $display("FAIL pwr_on_done_busy d%0d: done=%h busy=%h", d, done, busy);
      end
    end
  endtask

  task automatic test_power_off();
    issue(3, 1'b0, 4);
    for (int d = 0; d <= CH + 1; d++) begin
      if (d > 0) @(negedge clk);
      n_vec++;
      if (clk_en !== ((d < CH) ? 16'h0008 : 16'h0000)) begin
        n_err++;
        $display("FAIL pwr_off_clk_en d%0d: got %h required %h", d, clk_en, (d < CH) ? 16'h0008 : 16'h0000);
      end
      n_vec++;
      if (rst_n !== 16'h0000 || t_on !== 16'h0000) begin
        n_err++;
        $display("FAIL pwr_off_rst_on d%0d: rst_n=%h on=%h required 0000", d, rst_n, t_on);
      end
      n_vec++;
      if (done !== ((d == CH) ? 16'h0008 : 16'h0000)) begin
        n_err++;
        $display("FAIL pwr_off_done d%0d: got %h required %h", d, done, (d == CH) ? 16'h0008 : 16'h0000);
      end
    end
  endtask

  task automatic test_stall();
    issue(5, 1'b1, 4);
    cmd_valid = 1'b1;
    cmd_tile  = 4'd5;
    cmd_on    = 1'b0;
    for (int d = 0; d <= RH; d++) begin
      if (d > 0) @(negedge clk);
      #1;
      n_vec++;
      if (cmd_ready !== (d >= RH) || t_on[5] !== (d >= RH)) begin
        n_err++;
        $display("FAIL stall_ready d%0d: ready=%b on5=%b required %b", d, cmd_ready, t_on[5], d >= RH);
      end
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    $display("cmd tile=5 on=0 accepted after %0d stall cycles", RH);
    for (int d = 0; d <= CH + 1; d++) begin
      if (d > 0) @(negedge clk);
      n_vec++;
      if (rst_n[5] !== 1'b0 || clk_en[5] !== (d < CH) || done[5] !== (d == CH)) begin
        n_err++;
        $display("FAIL stall_pwrdn d%0d: rst_n5=%b clk_en5=%b done5=%b required 0/%b/%b", d, rst_n[5], clk_en[5], done[5], d < CH, d == CH);
      end
    end
  endtask

  task automatic test_back_to_back();
    cmd_valid = 1'b1;
    cmd_on    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cmd_tile = 4'(i);
      #1;
      n_vec++;
      if (cmd_ready !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_ready tile%0d: got %b required 1", i, cmd_ready);
      end
      @(posedge clk);
      @(negedge clk);
      $display("cmd tile=%0d on=1 accepted after 0 stall cycles", i);
    end
    cmd_valid = 1'b0;
    for (int d = 2; d <= RH + 3; d++) begin
      if (d > 2) @(negedge clk);
      n_vec++;
      if (done !== {13'd0, d == RH + 2, d == RH + 1, d == RH}) begin
        n_err++;
        $display("FAIL b2b_done d%0d: got %h", d, done);
      end
      n_vec++;
      if (busy[2:0] !== {d < RH + 2, d < RH + 1, d < RH}) begin
        n_err++;
        $display("FAIL b2b_busy d%0d: got %b", d, busy[2:0]);
      end
      n_vec++;
      if ((rst_n & ~clk_en) !== 16'h0000) begin
        n_err++;
        $display("FAIL b2b_invariant d%0d: rst_n=%h clk_en=%h", d, rst_n, clk_en);
      end
    end
  endtask

  task automatic test_err();
    v2  = 1'b1;
    t2  = 5'd20;
    on2 = 1'b1;
    #1;
    n_vec++;
    if (r2 !== 1'b1) begin
      n_err++;
      $display("FAIL err_ready: got %b required 1", r2);
    end
    @(posedge clk);
    @(negedge clk);
    v2 = 1'b0;
    $display("cmd20 tile=20 on=1 accepted after 0 stall cycles");
    n_vec++;
    if (e2 !== 1'b1 || err !== 1'b0) begin
      n_err++;
      $display("FAIL err_pulse: err20=%b err16=%b required 1/0", e2, err);
    end
    n_vec++;
    if ({ce2, rn2, b2, d2} !== 80'd0) begin
      n_err++;
      $display("FAIL err_no_effect: clk_en=%h rst_n=%h busy=%h done=%h required 0", ce2, rn2, b2, d2);
    end
    @(negedge clk);
    n_vec++;
    if (e2 !== 1'b0) begin
      n_err++;
      $display("FAIL err_one_cycle: got %b required 0", e2);
    end
  endtask

  task automatic test_rst_mid();
    issue(7, 1'b1, 4);
    repeat (3) @(negedge clk);
    n_vec++;
    if (busy[7] !== 1'b1 || clk_en[7] !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_pre: busy7=%b clk_en7=%b required 1/1", busy[7], clk_en[7]);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      n_vec++;
      if ({clk_en, rst_n, busy, done} !== '0) begin
        n_err++;
        $display("FAIL rstmid_off c%0d: clk_en=%h rst_n=%h busy=%h done=%h required 0", i, clk_en, rst_n, busy, done);
      end
    end
  endtask

  task automatic test_redundant();
    issue(3, 1'b1, 4);
    repeat (RH) @(negedge clk);
    issue(3, 1'b1, 4);
    n_vec++;
    if (done !== 16'h0008 || clk_en !== 16'h0008 || rst_n !== 16'h0008 || busy !== 16'h0000) begin
      n_err++;
      $display("FAIL redundant_on: done=%h clk_en=%h rst_n=%h busy=%h required 0008/0008/0008/0000", done, clk_en, rst_n, busy);
    end
    @(negedge clk);
    n_vec++;
    if (done !== 16'h0000 || rst_n !== 16'h0008) begin
      n_err++;
      $display("FAIL redundant_on_after: done=%h rst_n=%h required 0000/0008", done, rst_n);
    end
    issue(9, 1'b0, 4);
    n_vec++;
    if (done !== 16'h0200 || clk_en[9] !== 1'b0 || busy[9] !== 1'b0) begin
      n_err++;
      $display("FAIL redundant_off: done=%h clk_en9=%b busy9=%b required 0200/0/0", done, clk_en[9], busy[9]);
    end
  endtask

  task automatic test_random();
    logic last_ready;
    logic [NT-1:0] eb;
    last_ready = 1'b0;
    for (int it = 0; it < 500; it++) begin
      @(negedge clk);
      eb = exp_busy();
      n_vec++;
      if (busy !== eb || clk_en !== (eb | m_tgt) || rst_n !== (~eb & m_tgt) || t_on !== (~eb & m_tgt)) begin
        n_err++;
        $display("FAIL rand_state it%0d: busy=%h/%h clk_en=%h/%h rst_n=%h/%h on=%h", it, busy, eb, clk_en, eb | m_tgt, rst_n, ~eb & m_tgt, t_on);
      end
      n_vec++;
      if (done !== exp_done() || err !== 1'b0 || (rst_n & ~clk_en) !== 16'h0000) begin
        n_err++;
        $display("FAIL rand_done it%0d: done=%h required %h err=%b", it, done, exp_done(), err);
      end
      if (cmd_valid && last_ready) begin
        $display("cmd tile=%0d on=%0d accepted (random)", cmd_tile, cmd_on);
      end
      if (!cmd_valid || last_ready) begin
        cmd_valid = ($urandom_range(0, 2) != 0);
        cmd_tile  = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
        cmd_on    = 1'($urandom_range(0, 1));
      end
      #1;
      n_vec++;
      if (cmd_ready !== (cyc >= m_end[cmd_tile])) begin
        n_err++;
        $display("FAIL rand_ready it%0d tile%0d: got %b required %b", it, cmd_tile, cmd_ready, cyc >= m_end[cmd_tile]);
      end
      last_ready = cmd_ready;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_power_on();
    test_power_off();
    test_stall();
    test_back_to_back();
    test_err();
    test_rst_mid();
    test_redundant();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tile_pwr_seq.md
Name: tile_pwr_seq

Overview:
- Per-tile clock-enable/reset sequencer for the mesh tiles (clusters, memory tiles, SPU).
- Produces the `tile_clk_en` / `tile_rst_n` pairs that each tile consumes.
- Accepts power-on/off commands from the chip-control register path over a valid/ready port.
- On power-on it enables the clock, holds reset for a programmable number of cycles, then releases reset. Power-off runs the inverse order. Tiles sequence independently and concurrently.

Parameters:
- NumTiles, 16: number of sequenced tiles; 1..64.
- RstHoldCycles, 8: cycles reset stays asserted after the clock is enabled on power-on; >=1.
- ClkHoldCycles, 4: cycles the clock stays enabled after reset is asserted on power-off; >=1.
- CntW, $clog2(max(RstHoldCycles,ClkHoldCycles)+1): derived counter width; not overridable.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command accepted when cmd_valid_i & cmd_ready_o.
- cmd_tile_i  in  $clog2(NumTiles) (min 1)  target tile index.
- cmd_on_i  in  1  1 = power on, 0 = power off.
- tile_clk_en_o  out  NumTiles  per-tile clock enable.
- tile_rst_no  out  NumTiles  per-tile active-low reset.
- tile_on_o  out  NumTiles  tile is in state ON.
- busy_o  out  NumTiles  tile is in a transitional state.
- done_o  out  NumTiles  one-cycle pulse when a command for that tile completes.
- err_o  out  1  one-cycle pulse when an accepted command had an out-of-range index.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. All state updates on the rising edge of clk_i.
- Reset (rst_i=1 at an edge): every tile enters OFF and its counter is cleared.
  - Outputs after reset: tile_clk_en_o=0, tile_rst_no=0, tile_on_o=0, busy_o=0, done_o=0, err_o=0.
  - rst_i asserted mid-sequence forces OFF immediately, with no done pulse.
- All outputs are registered or decoded from state registers; no output depends combinationally on cmd_* except cmd_ready_o.
- Per-tile FSM, with outputs (clk_en, rst_n) in each state:
  - OFF (0,0).
  - PWRUP (1,0).
  - ON (1,1).
  - PWRDN (1,0).
- cmd_ready_o = target tile in OFF or ON, or cmd_tile_i >= NumTiles. A command to a busy tile stalls and is not dropped; the requester must hold valid and stable payload until ready.
- Accepted command, in-range, at edge k:
  - on & OFF -> PWRUP, counter = RstHoldCycles-1.
  - off & ON -> PWRDN, counter = ClkHoldCycles-1.
  - on & ON, or off & OFF: no state change; done_o[t]=1 in the cycle after edge k.
- PWRUP: each edge decrements the counter; at an edge where counter==0 -> ON.
  - Hence tile_clk_en_o[t] rises after edge k and tile_rst_no[t] rises after edge k+RstHoldCycles.
  - done_o[t] pulses in the same cycle tile_rst_no[t] rises.
- PWRDN: tile_rst_no[t] falls after edge k; at the counter==0 edge -> OFF.
  - tile_clk_en_o[t] falls after edge k+ClkHoldCycles; done_o[t] pulses in that same cycle.
- Invariant: tile_rst_no[t]=1 implies tile_clk_en_o[t]=1 in every cycle. Reset is never released without a running clock, and the clock is never gated while reset is deasserted.
- Out-of-range index: accepted (ready=1); err_o pulses in the next cycle; no tile is affected.
- Concurrency:
  - Different tiles may be in PWRUP/PWRDN simultaneously; multiple done_o bits may pulse in the same cycle.
  - A command accepted for tile t at the edge where t completes is impossible, because ready is 0 while t is busy.
  - A command accepted for tile u!=t in the cycle t completes is handled normally.
- Counter arithmetic: unsigned, CntW bits, no wrap (loaded only in OFF/ON, decremented only while nonzero in PWRUP/PWRDN).
- busy_o[t] = state in {PWRUP, PWRDN}; tile_on_o[t] = state==ON.

Test Plan:
- Reset release -> all 16 tiles clk_en=0, rst_n=0, ready=1; no done or err pulses for 10 cycles.
- Power on tile 3 at edge k (RstHold=8) -> clk_en[3]=1 after k; rst_n[3]=1 and done_o[3] pulse after k+8; other tiles unchanged.
- Power off tile 3 from ON at edge j (ClkHold=4) -> rst_n[3]=0 after j; clk_en[3]=0 and done_o[3] after j+4; tile_on_o[3]=0.
- Command to tile 5 while it is in PWRUP -> cmd_ready_o=0 until tile 5 reaches ON. The held off-command is then accepted and completes 4 cycles later.
- Back-to-back power-on of tiles 0, 1, 2 on consecutive cycles -> three staggered done pulses 8 cycles after each acceptance; invariant rst_n=>clk_en checked every cycle.
- cmd_tile_i=20 -> accepted, err_o pulse, no state change.
- rst_i mid-PWRUP of tile 7 -> OFF next cycle, no done pulse.
- Redundant on-command to an ON tile -> done_o pulse next cycle, outputs unchanged.
